// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF stage.
// The stall bus carries one bit per pipeline register (bit0 = PC, bit1 = IF/ID,
// bit2 = ID/EX, ...); a set bit means that register holds its value.
// The widths of the IF->ID bus and the branch bus, and the address of the
// first fetched instruction, are also defined here.
package if_fetch_unit_pkg;

  localparam int STALL_BUS_W = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Index of each pipeline register within the stall bus.
  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;

endpackage

// File: rtl/if_inst_hold.sv
// Holds the word returned by a synchronous SRAM while the consuming pipeline
// register is stalled.
// The SRAM gives its data exactly one cycle after the request is made. If the
// consumer is stalled, that data would otherwise be lost on the next cycle.
// The same block can hold read data from the data SRAM in the MEM stage.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous, active-high reset
//   hold  - consumer register is stalled (STOP)
//   rdata - raw SRAM read data
//   data  - held word while holding, otherwise rdata
module if_inst_hold
  import if_fetch_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] data
);

  logic         hold_v;
  logic [W-1:0] hold_data;

  // Capture only on the first stalled cycle. That is the one cycle in which
  // rdata still belongs to the consumer. Later cycles show the data for
  // whatever address was presented afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
    end else if (hold == STOP) begin
      if (!hold_v) begin
        hold_data <= rdata;
        hold_v    <= 1'b1;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  assign data = hold_v ? hold_data : rdata;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// This module owns the PC and drives the instruction SRAM. It takes branch
// redirects resolved in ID and presents {ce, pc} to ID, together with the
// instruction that matches the PC currently held in ID.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   stall           - per-stage stall vector (bit0 PC, bit1 IF/ID, bit2 ID/EX)
//   br_bus          - {br_e, br_addr} from ID
//   if_to_id_bus    - {ce, pc} to ID
//   inst_sram_*     - instruction SRAM request/response
//   inst_to_id      - instruction for the PC held in the ID register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          STALL_W  = STALL_BUS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            inst_to_id
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_pend_v;
  logic [31:0] br_pend_addr;
  logic [31:0] next_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // A live branch has priority over a pending one, because it is newer.
  // The pending target is used only when a redirect arrived while the PC
  // was frozen.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (br_pend_v) begin
      next_pc = br_pend_addr;
    end
  end

  // The PC resets to RESET_PC-4 with ce low, so the first real fetch of
  // RESET_PC happens on the first advancing edge after reset.
  // A redirect seen while the PC is stalled is remembered here. ID presents
  // br_e for only one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC - 32'd4;
      ce_reg       <= 1'b0;
      br_pend_v    <= 1'b0;
      br_pend_addr <= '0;
    end else if (stall[STALL_PC] == NO_STOP) begin
      pc_reg    <= next_pc;
      ce_reg    <= 1'b1;
      br_pend_v <= 1'b0;
    end else if (br_e) begin
      br_pend_v    <= 1'b1;
      br_pend_addr <= br_addr;
    end
  end

  assign inst_sram_en    = ce_reg;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign if_to_id_bus    = {ce_reg, pc_reg};

  // ID keeps its PC whenever IF/ID is stalled, whether or not ID/EX also
  // stalls. For that reason only stall bit1 controls the instruction hold.
  if_inst_hold #(
    .W(32)
  ) u_inst_hold (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall[STALL_IF_ID]),
    .rdata (inst_sram_rdata),
    .data  (inst_to_id)
  );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline; upstream end of the IF→ID interface.
- Owns the PC register and drives the synchronous instruction SRAM request.
- Consumes the branch bus resolved in ID, produces the IF→ID bus, and holds the returned instruction stable while ID is stalled.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction.
- STALL_W, 6, width of the stall bus (`StallBus`).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- stall  in  STALL_W  per-stage stall vector from the controller; bit0=PC, bit1=IF/ID, bit2=ID/EX; `Stop`=1.
- br_bus  in  33  {br_e, br_addr[31:0]} from ID.
- if_to_id_bus  out  33  {ce, pc[31:0]}.
- inst_sram_en  out  1  instruction SRAM enable.
- inst_sram_wen  out  4  always 4'b0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  always 32'b0.
- inst_sram_rdata  in  32  SRAM data; valid 1 cycle after the address was presented.
- inst_to_id  out  32  instruction for the PC currently held in the ID register.

Behaviour:
- Registers: pc_reg, ce_reg, br_pend_v, br_pend_addr, hold_v, hold_inst.
- Reset (rst=1 at posedge):
  - pc_reg <= RESET_PC-4 (32'hBFBF_FFFC), ce_reg <= 0.
  - br_pend_v <= 0, hold_v <= 0, hold_inst <= 0.
  - While in reset, outputs are en=0, addr=32'hBFBF_FFFC, if_to_id_bus=33'h0_BFBF_FFFC, inst_to_id=inst_sram_rdata.
- Next-PC selection, by priority:
  - br_e=1: br_addr.
  - br_pend_v=1: br_pend_addr.
  - otherwise: pc_reg+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Advance (stall[0]=NoStop): pc_reg <= next_pc, ce_reg <= 1, br_pend_v <= 0.
- Branch arriving under PC stall (br_e=1 and stall[0]=Stop):
  - br_pend_v <= 1, br_pend_addr <= br_addr.
  - A later br_e=1 overwrites the pending target.
  - br_e=1 and stall[0]=NoStop in the same cycle: br_addr is used and the pending entry is cleared.
- Delay slot: the instruction after the branch is already fetched when br_e is seen. It is never squashed; the target becomes the second fetch after the branch.
- SRAM drive (combinational): inst_sram_en=ce_reg, inst_sram_addr=pc_reg.
  - First fetch: the cycle after rst deasserts, with addr=RESET_PC.
  - An address is re-presented each stall cycle.
- if_to_id_bus = {ce_reg, pc_reg}, combinational.
- Instruction hold:
  - ID latches pc at posedge N; the matching instruction is on inst_sram_rdata during cycle N+1 only.
  - Capture: if stall[1]=Stop and hold_v=0, then hold_inst <= inst_sram_rdata and hold_v <= 1.
  - Release: if stall[1]=NoStop, hold_v <= 0.
  - Output: inst_to_id = hold_v ? hold_inst : inst_sram_rdata.
  - Bubble case (stall[1]=Stop, stall[2]=NoStop): capture behaves identically, since ID retains its PC.
- Latency: pc change → SRAM address same cycle → instruction 1 cycle later.
- Mid-operation reset: wins over everything. Pending branch and hold are discarded in the same edge.

Decomposition:
- Shared defines header (already in use): `StallBus`, `Stop`/`NoStop`, `IF_TO_ID_WD`=33, `BR_WD`=33, reset-PC constant.
- One sub-module is natural: if_inst_hold (capture/release register plus output mux), reusable for data-SRAM read hold in MEM.
- PC/branch-pending logic stays in the top module.

Test Plan:
- Reset release, no stall → addr sequence BFC0_0000, BFC0_0004, BFC0_0008; ce=1 from the first cycle after reset.
- br_e=1 with br_addr=BFC0_0100 while pc_reg=BFC0_0008, no stall → next cycle addr=BFC0_0100. The delay-slot instruction at BFC0_0008 still reaches ID.
- stall[0]=Stop for 3 cycles with br_e=1 (addr=BFC0_0200) pulsed in cycle 1 → pc_reg frozen during the stall. Next advance gives addr=BFC0_0200 and br_pend_v clears.
- ID pc=BFC0_0004 and inst 0x3C01_1234 on rdata, stall[1]=Stop for 4 cycles while rdata changes to 0xDEADBEEF → inst_to_id stays 0x3C01_1234 throughout. It follows rdata again after release.
- pc_reg=FFFF_FFFC, no branch → next addr=0000_0000.
- rst asserted mid-stream with hold_v=1 and br_pend_v=1 → next cycle en=0, both flags 0, then the fetch restarts at BFC0_0000.
